exp_sigma_table_reader: RTL and testbench
=========================================

// Module: exp_sigma_table_reader
// PURPOSE
//  Consumer end of the exp(x*sigma) table stream. Starts the table generator,
//  captures its (oAddr, oData, oValid, oDone) stream into an on-chip RAM and
//  then serves pipelined lookups of exp(x*sigma) by signed x to the risk datapath.
//  Owns table validity: rebuild on request, fill-count check, watchdog.
// PARAMETERS
//  X_MIN       -307  smallest table x (signed, 8 int / 2 fract)
//  X_MAX        280  largest table x
//  PATH_WIDTH   10   width of x / address
//  DATA_WIDTH   18   table entry width (3 int, 15 fract)
//  DEPTH        588  entries = X_MAX-X_MIN+1
//  TIMEOUT     2047  max cycles from oStart to iGenDone
// PORTS
//  CLK         in   1           clock, all logic on rising edge
//  iRSTn       in   1           asynchronous active-low reset
//  iLoad       in   1           request (re)build of the table
//  oStart      out  1           one-cycle start pulse to generator
//  iGenData    in   DATA_WIDTH  generator entry
//  iGenAddr    in   PATH_WIDTH  generator x (signed)
//  iGenValid   in   1           generator entry valid
//  iGenDone    in   1           generator finished (one-cycle pulse)
//  iReqValid   in   1           lookup request
//  iReqX       in   PATH_WIDTH  lookup x (signed)
//  oReqReady   out  1           lookup accepted when iReqValid&oReqReady
//  oRespValid  out  1           response valid (one-cycle, no backpressure)
//  oRespData   out  DATA_WIDTH  exp(x*sigma) entry
//  oRespClamp  out  1           request x was out of range and saturated
//  oTableReady out  1           table complete and readable
//  oError      out  1           sticky: bad fill count or watchdog expiry
// BEHAVIOUR
//  Reset (async, iRSTn=0): state EMPTY; oStart, oReqReady, oRespValid, oRespClamp,
//   oTableReady, oError = 0; oRespData = 0; write count and watchdog = 0.
//   RAM contents not cleared. Reset mid-fill returns to EMPTY; generator stream ignored.
//  FSM: EMPTY -> (iLoad) START -> FILLING -> (iGenDone) READY; READY -> (iLoad) START.
//   START: lasts one cycle, oStart=1, clears count and watchdog, clears oError.
//   FILLING: each iGenValid writes RAM[iGenAddr-X_MIN] <= iGenData, count++.
//    Address outside [X_MIN,X_MAX] while valid: no write, oError=1.
//    iGenDone: count==DEPTH -> READY, oTableReady=1; else EMPTY, oError=1.
//    iGenValid and iGenDone same cycle: write counted before check.
//    Watchdog reaches TIMEOUT with no iGenDone: EMPTY, oError=1.
//    iLoad in START/FILLING ignored. iGen* in EMPTY/READY ignored.
//  oTableReady=1 only in READY; oReqReady = oTableReady (combinational from state reg).
//  Lookup: accepted request -> oRespValid exactly 2 cycles later (cycle 1 RAM read,
//   cycle 2 output reg). One request per cycle, fully pipelined, order preserved.
//   iReqX<X_MIN reads X_MIN entry, iReqX>X_MAX reads X_MAX entry, oRespClamp=1
//   with that response; else oRespClamp=0. oRespData holds last value when idle.
//  iLoad in READY: oReqReady drops next cycle; requests already accepted still
//   respond from pre-rebuild contents (generator latency > 2 cycles).
//  Index arithmetic: sign-extend to PATH_WIDTH+1 before subtracting X_MIN; no wrap.
// TESTING
//  1 Reset, iLoad, model generator emits x=-307..280 then done -> oStart one pulse,
//    oTableReady=1 the cycle after iGenDone, oError=0.
//  2 After fill, back-to-back requests x=-307,0,280 -> three responses on
//    consecutive cycles, 2 cycles after each accept, data equal to written entries.
//  3 Requests x=-400 and x=300 -> entries for -307 and 280, oRespClamp=1 each.
//  4 Generator drops one entry (587 writes) then done -> state EMPTY, oError=1,
//    oReqReady=0; next iLoad clears oError.
//  5 Generator never asserts done -> after 2047 cycles oError=1, oTableReady=0.
//  6 iRSTn low mid-fill (after 100 writes) -> all outputs 0 immediately, remaining
//    stream ignored; iLoad then full stream -> oTableReady=1.

Source files
------------

// File: rtl/exp_sigma_table_reader.sv
// exp_sigma_table_reader
//   Consumer end of the exp(x*sigma) table stream. Kicks the table generator
//   with a one-cycle start pulse, captures its (addr, data, valid, done) stream
//   into an on-chip RAM indexed by x - X_MIN, and then serves fully pipelined
//   lookups by signed x with saturation at the table ends. Owns table
//   validity: rebuild on request, fill-count check and a fill watchdog.
//
// Ports
//   CLK          clock, all logic on the rising edge
//   iRSTn        asynchronous active-low reset
//   iLoad        request a (re)build of the table
//   oStart       one-cycle start pulse to the generator
//   iGenData     generator table entry
//   iGenAddr     generator x (signed)
//   iGenValid    generator entry valid
//   iGenDone     generator finished (one-cycle pulse)
//   iReqValid    lookup request
//   iReqX        lookup x (signed)
//   oReqReady    lookup accepted when iReqValid & oReqReady
//   oRespValid   response valid, two cycles after accept, no backpressure
//   oRespData    looked-up entry, holds the last value when idle
//   oRespClamp   the request x was out of range and was saturated
//   oTableReady  table complete and readable
//   oError       sticky: bad fill count, bad generator address or watchdog expiry

module exp_sigma_table_reader #(
  parameter int X_MIN      = -307,
  parameter int X_MAX      = 280,
  parameter int PATH_WIDTH = 10,
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = X_MAX - X_MIN + 1,
  parameter int TIMEOUT    = 2047
) (
  input  logic                  CLK,
  input  logic                  iRSTn,
  input  logic                  iLoad,
  output logic                  oStart,
  input  logic [DATA_WIDTH-1:0] iGenData,
  input  logic [PATH_WIDTH-1:0] iGenAddr,
  input  logic                  iGenValid,
  input  logic                  iGenDone,
  input  logic                  iReqValid,
  input  logic [PATH_WIDTH-1:0] iReqX,
  output logic                  oReqReady,
  output logic                  oRespValid,
  output logic [DATA_WIDTH-1:0] oRespData,
  output logic                  oRespClamp,
  output logic                  oTableReady,
  output logic                  oError
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int XW     = PATH_WIDTH + 1;

  localparam logic signed [XW-1:0] XMinExt     = XW'(X_MIN);
  localparam logic signed [XW-1:0] LastOff     = XW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0]    LastIdx     = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]     DepthCnt    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]     TimeoutLast = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    EMPTY,
    START,
    FILLING,
    READY
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic              error_q, error_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  memWe;

  // Offsets are formed one bit wider than x so that x - X_MIN can never wrap;
  // a negative offset or one past the last entry means x is off the table.
  logic signed [XW-1:0] genOff;
  logic signed [XW-1:0] reqOff;
  logic [ADDR_W-1:0]    genIdx;
  logic                 genInRange;
  logic [ADDR_W-1:0]    reqIdx;
  logic                 reqClamp;
  logic                 reqFire;

  assign genOff     = $signed({iGenAddr[PATH_WIDTH-1], iGenAddr}) - XMinExt;
  assign reqOff     = $signed({iReqX[PATH_WIDTH-1], iReqX}) - XMinExt;
  assign genIdx     = genOff[ADDR_W-1:0];
  assign genInRange = !genOff[XW-1] && (genOff <= LastOff);

  // Saturate out-of-range lookups to the nearest table end and flag it.
  always_comb begin
    reqIdx   = reqOff[ADDR_W-1:0];
    reqClamp = 1'b0;
    if (reqOff[XW-1]) begin
      reqIdx   = '0;
      reqClamp = 1'b1;
    end else if (reqOff > LastOff) begin
      reqIdx   = LastIdx;
      reqClamp = 1'b1;
    end
  end

  // Control registers; reset mid-fill simply drops back to EMPTY.
  always_ff @(posedge CLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= EMPTY;
      count_q <= '0;
      wdog_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wdog_q  <= wdog_d;
      error_q <= error_d;
    end
  end

  // Next-state logic. The rebuild bookkeeping (count, watchdog, sticky error)
  // is cleared on the way into START so the error flag is already low while
  // the start pulse is out. A write that coincides with iGenDone is counted
  // before the fill-count check.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wdog_d  = wdog_q;
    error_d = error_q;
    memWe   = 1'b0;
    unique case (state_q)
      EMPTY, READY: begin
        if (iLoad) begin
          state_d = START;
          count_d = '0;
          wdog_d  = '0;
          error_d = 1'b0;
        end
      end
      START: begin
        state_d = FILLING;
      end
      FILLING: begin
        memWe   = iGenValid && genInRange;
        count_d = count_q + {{(CNT_W-1){1'b0}}, memWe};
        wdog_d  = wdog_q + CNT_W'(1);
        if (iGenValid && !genInRange) begin
          error_d = 1'b1;
        end
        if (iGenDone) begin
          if (count_d == DepthCnt) begin
            state_d = READY;
          end else begin
            state_d = EMPTY;
            error_d = 1'b1;
          end
        end else if (wdog_q == TimeoutLast) begin
          state_d = EMPTY;
          error_d = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  assign oStart      = (state_q == START);
  assign oTableReady = (state_q == READY);
  assign oReqReady   = oTableReady;
  assign oError      = error_q;
  assign reqFire     = iReqValid && oReqReady;

  // Table RAM: contents survive reset. Writes only happen while FILLING, so a
  // lookup accepted in READY always reads settled pre-rebuild data.
  logic [DATA_WIDTH-1:0] rdData_q;

  always_ff @(posedge CLK) begin
    if (memWe) begin
      mem[genIdx] <= iGenData;
    end
    if (reqFire) begin
      rdData_q <= mem[reqIdx];
    end
  end

  // Two-stage lookup pipeline: RAM read, then output register.
  logic                  rdValid_q;
  logic                  rdClamp_q;
  logic                  respValid_q;
  logic                  respClamp_q;
  logic [DATA_WIDTH-1:0] respData_q;

  always_ff @(posedge CLK or negedge iRSTn) begin
    if (!iRSTn) begin
      rdValid_q   <= 1'b0;
      rdClamp_q   <= 1'b0;
      respValid_q <= 1'b0;
      respClamp_q <= 1'b0;
      respData_q  <= '0;
    end else begin
      rdValid_q   <= reqFire;
      rdClamp_q   <= reqFire && reqClamp;
      respValid_q <= rdValid_q;
      respClamp_q <= rdValid_q && rdClamp_q;
      if (rdValid_q) begin
        respData_q <= rdData_q;
      end
    end
  end

  assign oRespValid = respValid_q;
  assign oRespClamp = respClamp_q;
  assign oRespData  = respData_q;

endmodule

// File: tb/tb_exp_sigma_table_reader.sv
// Testbench for exp_sigma_table_reader. A model generator fills the table with
// random entries; a reference table keyed by x predicts every lookup result.

module tb_exp_sigma_table_reader;

  localparam int X_MIN = -307;
  localparam int X_MAX = 280;
  localparam int PW    = 10;
  localparam int DW    = 18;

  logic          CLK = 1'b0;
  logic          iRSTn;
  logic          iLoad;
  logic          oStart;
  logic [DW-1:0] iGenData;
  logic [PW-1:0] iGenAddr;
  logic          iGenValid;
  logic          iGenDone;
  logic          iReqValid;
  logic [PW-1:0] iReqX;
  logic          oReqReady;
  logic          oRespValid;
  logic [DW-1:0] oRespData;
  logic          oRespClamp;
  logic          oTableReady;
  logic          oError;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [DW-1:0] refTable [int];
  logic [DW-1:0] lastResp = '0;
  int            reqQ [$];

  always #5 CLK = ~CLK;

  exp_sigma_table_reader dut (
    .CLK        (CLK),
    .iRSTn      (iRSTn),
    .iLoad      (iLoad),
    .oStart     (oStart),
    .iGenData   (iGenData),
    .iGenAddr   (iGenAddr),
    .iGenValid  (iGenValid),
    .iGenDone   (iGenDone),
    .iReqValid  (iReqValid),
    .iReqX      (iReqX),
    .oReqReady  (oReqReady),
    .oRespValid (oRespValid),
    .oRespData  (oRespData),
    .oRespClamp (oRespClamp),
    .oTableReady(oTableReady),
    .oError     (oError)
  );

  // Advance to 1 time unit after the next rising edge (sample/drive point).
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load();
    iLoad = 1'b1;
    step();
    iLoad = 1'b0;
  endtask

  // Model generator, called in a FILLING cycle. Emits x = X_MIN..X_MAX with
  // random idle gaps, optionally dropping skipX, stopping after stopAfter writes.
  task automatic gen_stream(input int skipX, input bit sendDone, input bit doneWithLast,
                            input int stopAfter);
    int          nWritten = 0;
    logic [31:0] r;
    for (int x = X_MIN; x <= X_MAX; x++) begin
      if (stopAfter >= 0 && nWritten == stopAfter) break;
      if (x == skipX) continue;
      while ($urandom_range(0, 7) == 0) begin
        iGenValid = 1'b0;
        step();
      end
      r         = $urandom;
      iGenValid = 1'b1;
      iGenAddr  = x[PW-1:0];
      iGenData  = r[DW-1:0];
      refTable[x] = r[DW-1:0];
      iGenDone  = sendDone && doneWithLast && (x == X_MAX);
      step();
      nWritten++;
    end
    iGenValid = 1'b0;
    if (sendDone && !doneWithLast) begin
      iGenDone = 1'b1;
      step();
    end
    iGenDone = 1'b0;
  endtask

  // Issues every x in reqQ (back-to-back or with random gaps) and checks each
  // response lands exactly two cycles after its accept with the model value.
  task automatic run_lookups(input string name, input bit gaps);
    int            dueQ [$];
    logic [DW-1:0] dQ [$];
    bit            cQ [$];
    int            total = reqQ.size();
    int            x;
    int            xc;
    bit            expV;
    for (int it = 0; it < 4 * total + 8 && (reqQ.size() > 0 || dueQ.size() > 0); it++) begin
      expV = (dueQ.size() > 0) && (dueQ[0] == it);
      nCompared++;
      if (oRespValid !== expV) begin
        nMismatched++;
        $display("[TB] FAIL %s resp_valid it=%0d got=%b want=%b", name, it, oRespValid, expV);
      end
      if (expV) begin
        nCompared++;
        if (oRespData !== dQ[0] || oRespClamp !== cQ[0]) begin
          nMismatched++;
          $display("[TB] FAIL %s resp_data it=%0d got=%h/%b want=%h/%b", name, it,
                   oRespData, oRespClamp, dQ[0], cQ[0]);
        end
        lastResp = dQ[0];
        void'(dueQ.pop_front());
        void'(dQ.pop_front());
        void'(cQ.pop_front());
      end else begin
        nCompared++;
        if (oRespData !== lastResp || oRespClamp !== 1'b0) begin
          nMismatched++;
          $display("[TB] FAIL %s idle_hold it=%0d got=%h/%b want=%h/0", name, it,
                   oRespData, oRespClamp, lastResp);
        end
      end
      if (reqQ.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        x  = reqQ.pop_front();
        xc = (x < X_MIN) ? X_MIN : ((x > X_MAX) ? X_MAX : x);
        nCompared++;
        if (oReqReady !== 1'b1) begin
          nMismatched++;
          $display("[TB] FAIL %s req_ready it=%0d got=%b want=1", name, it, oReqReady);
        end
        iReqValid = 1'b1;
        iReqX     = x[PW-1:0];
        dueQ.push_back(it + 2);
        dQ.push_back(refTable[xc]);
        cQ.push_back(xc != x);
      end else begin
        iReqValid = 1'b0;
      end
      step();
    end
    iReqValid = 1'b0;
    nCompared++;
    if (dueQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL %s missing_resp got=%0d outstanding want=0", name, dueQ.size());
    end
  endtask

  task automatic test_reset();
    nCompared++;
    if ({oStart, oReqReady, oRespValid, oRespClamp, oTableReady, oError} !== 6'b0 ||
        oRespData !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs got=%b%b%b%b%b%b data=%h want=all zero", oStart,
               oReqReady, oRespValid, oRespClamp, oTableReady, oError, oRespData);
    end
  endtask

  task automatic test_full_fill(input string name, input bit doneWithLast);
    do_load();
    nCompared++;
    if (oStart !== 1'b1 || oTableReady !== 1'b0 || oError !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL %s start got=%b/%b/%b want=1/0/0", name, oStart, oTableReady, oError);
    end
    step();
    nCompared++;
    if (oStart !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL %s start_one_shot got=%b want=0", name, oStart);
    end
    gen_stream(X_MAX + 1, 1'b1, doneWithLast, -1);
    nCompared++;
    if (oTableReady !== 1'b1 || oError !== 1'b0 || oReqReady !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL %s ready got=%b/%b/%b want=1/0/1", name, oTableReady, oError, oReqReady);
    end
  endtask

  task automatic test_back_to_back();
    reqQ = '{X_MIN, 0, X_MAX};
    run_lookups("back_to_back", 1'b0);
  endtask

  task automatic test_clamp();
    reqQ = '{-400, 300, -512, 511, X_MIN - 1, X_MAX + 1};
    run_lookups("clamp", 1'b0);
  endtask

  task automatic test_random_lookup(input string name);
    reqQ.delete();
    for (int i = 0; i < 40; i++) begin
      reqQ.push_back(int'($urandom_range(0, 1023)) - 512);
    end
    run_lookups(name, 1'b1);
  endtask

  // Requests accepted just before a rebuild must still see the old contents.
  task automatic test_rebuild_inflight();
    int            x1 = int'($urandom_range(0, 587)) + X_MIN;
    int            x2 = int'($urandom_range(0, 587)) + X_MIN;
    logic [DW-1:0] old1 = refTable[x1];
    logic [DW-1:0] old2 = refTable[x2];
    iReqValid = 1'b1;
    iReqX     = x1[PW-1:0];
    step();
    iReqX = x2[PW-1:0];
    iLoad = 1'b1;
    step();
    iReqValid = 1'b0;
    iLoad     = 1'b0;
    nCompared++;
    if (oReqReady !== 1'b0 || oStart !== 1'b1 || oRespValid !== 1'b1 || oRespData !== old1) begin
      nMismatched++;
      $display("[TB] FAIL rebuild_first got=rdy%b st%b v%b %h want=rdy0 st1 v1 %h", oReqReady,
               oStart, oRespValid, oRespData, old1);
    end
    step();
    nCompared++;
    if (oRespValid !== 1'b1 || oRespData !== old2 || oTableReady !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL rebuild_second got=v%b %h tr%b want=v1 %h tr0", oRespValid, oRespData,
               oTableReady, old2);
    end
    lastResp = old2;
    gen_stream(X_MAX + 1, 1'b1, 1'b0, -1);
    nCompared++;
    if (oTableReady !== 1'b1 || oError !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL rebuild_ready got=%b/%b want=1/0", oTableReady, oError);
    end
  endtask

  task automatic test_short_fill();
    int skipX = int'($urandom_range(0, 587)) + X_MIN;
    do_load();
    step();
    gen_stream(skipX, 1'b1, 1'b0, -1);
    nCompared++;
    if (oError !== 1'b1 || oTableReady !== 1'b0 || oReqReady !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL short_fill got=err%b tr%b rr%b want=err1 tr0 rr0", oError, oTableReady,
               oReqReady);
    end
    do_load();
    nCompared++;
    if (oError !== 1'b0 || oStart !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL short_fill_reload got=err%b st%b want=err0 st1", oError, oStart);
    end
    step();
    gen_stream(X_MAX + 1, 1'b1, 1'b0, -1);
    nCompared++;
    if (oTableReady !== 1'b1 || oError !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL short_fill_recover got=%b/%b want=1/0", oTableReady, oError);
    end
  endtask

  task automatic test_watchdog();
    int firstErr = -1;
    do_load();
    for (int c = 0; c < 2200 && firstErr < 0; c++) begin
      if (oError === 1'b1) firstErr = c;
      else step();
    end
    nCompared++;
    if (firstErr < 2040 || firstErr > 2060) begin
      nMismatched++;
      $display("[TB] FAIL watchdog_time got=%0d cycles want=2040..2060", firstErr);
    end
    step();
    nCompared++;
    if (oError !== 1'b1 || oTableReady !== 1'b0 || oReqReady !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL watchdog_state got=err%b tr%b rr%b want=err1 tr0 rr0", oError,
               oTableReady, oReqReady);
    end
  endtask

  task automatic test_reset_midfill();
    logic [31:0] r;
    do_load();
    step();
    gen_stream(X_MAX + 1, 1'b0, 1'b0, 100);
    #2;
    iRSTn = 1'b0;
    #1;
    nCompared++;
    if ({oStart, oReqReady, oRespValid, oRespClamp, oTableReady, oError} !== 6'b0 ||
        oRespData !== '0) begin
      nMismatched++;
      $display("[TB] FAIL midfill_reset got=%b%b%b%b%b%b data=%h want=all zero", oStart,
               oReqReady, oRespValid, oRespClamp, oTableReady, oError, oRespData);
    end
    lastResp = '0;
    step();
    for (int x = X_MIN + 100; x <= X_MAX; x++) begin
      if (x == X_MIN + 103) iRSTn = 1'b1;
      r         = $urandom;
      iGenValid = 1'b1;
      iGenAddr  = x[PW-1:0];
      iGenData  = r[DW-1:0];
      iGenDone  = (x == X_MAX);
      step();
    end
    iGenValid = 1'b0;
    iGenDone  = 1'b0;
    nCompared++;
    if (oTableReady !== 1'b0 || oError !== 1'b0 || oStart !== 1'b0 || oRespData !== '0) begin
      nMismatched++;
      $display("[TB] FAIL midfill_ignored got=tr%b err%b st%b %h want=tr0 err0 st0 0",
               oTableReady, oError, oStart, oRespData);
    end
    test_full_fill("midfill_refill", 1'b1);
  endtask

  initial begin
    iRSTn     = 1'b0;
    iLoad     = 1'b0;
    iGenData  = '0;
    iGenAddr  = '0;
    iGenValid = 1'b0;
    iGenDone  = 1'b0;
    iReqValid = 1'b0;
    iReqX     = '0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    iRSTn = 1'b1;
    step();
    test_full_fill("fill_done_with_last", 1'b1);
    test_back_to_back();
    test_clamp();
    test_random_lookup("random_lookup");
    test_rebuild_inflight();
    test_random_lookup("post_rebuild_lookup");
    test_short_fill();
    test_watchdog();
    test_reset_midfill();
    test_random_lookup("post_reset_lookup");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
